thread_scheduler: RTL
=====================

Name: thread_scheduler

Overview:
- Fine-grained round-robin issue scheduler for the 2-thread interleaved core.
- Keeps a per-thread PC and run state, and picks one thread per cycle.
- Presents {tid, pc} to fetch through a valid/ready handshake.
- The issued tid travels down the pipeline and becomes r_thread_id / w_thread_id at the per-thread register file.

Parameters:
- PC_W, 16, width of the program counter.
- PC_INC, 1, PC increment per issued instruction.
- RESET_PC0, 16'h0000, thread 0 start PC.
- RESET_PC1, 16'h0080, thread 1 start PC.
- STRICT_ALT, 0, when 1 a thread never issues in two consecutive issue slots; a bubble is issued instead.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- thread_enable  in  2  bit t permits thread t to run (level).
- stall_req  in  2  bit t blocks thread t, e.g. a long-latency op (level).
- redirect_valid  in  1  branch/jump resolved.
- redirect_tid  in  1  thread being redirected.
- redirect_pc  in  PC_W  new PC.
- halt_valid  in  1  HALT retired.
- halt_tid  in  1  thread that halted.
- fetch_ready  in  1  fetch accepts the current issue.
- issue_valid  out  1  issue slot holds an instruction request.
- issue_tid  out  1  thread id of the issue.
- issue_pc  out  PC_W  PC to fetch.
- thread_state  out  4  [1:0] = thread 0, [3:2] = thread 1. Encoding: 00 IDLE, 01 RUN, 10 STALL, 11 HALTED.
- all_halted  out  1  both threads HALTED.
- bubble_count  out  16  count of cycles where a slot advanced with no issue; saturates at 16'hFFFF.

Behaviour:
Reset (async, rst=1):
- issue_valid=0, issue_tid=0, issue_pc=0.
- Both states IDLE; pc0=RESET_PC0, pc1=RESET_PC1.
- last_tid=1, so thread 0 wins first.
- bubble_count=0, all_halted=0.
- Reset mid-operation discards everything, including a held issue.

Per-thread FSM (registered, evaluated every edge):
- Priority: halt > enable low > stall.
- Any state except HALTED goes to HALTED if halt_valid and halt_tid==t. HALTED exits only by rst.
- RUN/STALL go to IDLE if thread_enable[t]=0. The PC is retained.
- IDLE goes to RUN if thread_enable[t]=1.
- RUN goes to STALL if stall_req[t]=1.
- STALL goes to RUN if stall_req[t]=0.

Eligibility (combinational, current cycle):
- elig[t] = state==RUN && !stall_req[t] && thread_enable[t] && !(halt_valid && halt_tid==t).
- A stall asserted in cycle N blocks the issue loaded at edge N.

Slot advance:
- Advance when !issue_valid || fetch_ready.
- If issue_valid && !fetch_ready, all issue outputs hold stable and no PC increments. Redirect and FSM updates still apply.

Selection on advance:
- Prefer !last_tid if eligible, else last_tid if eligible, else bubble.
- With STRICT_ALT=1, last_tid is never chosen when the previous advance issued it; that case is a bubble.
- Bubble: issue_valid<=0 and bubble_count increments (saturating). last_tid is unchanged.
- Issue of thread s: issue_valid<=1, issue_tid<=s, issue_pc<=pc[s], pc[s]<=pc[s]+PC_INC (mod 2^PC_W wrap), last_tid<=s.

Redirect:
- On redirect_valid, pc[redirect_tid]<=redirect_pc.
- Bypass: if the same thread is issued in the same cycle, issue_pc=redirect_pc and pc<=redirect_pc+PC_INC.
- Redirect of a HALTED or IDLE thread still updates its PC.
- Already-issued instructions are not squashed; the pipeline flushes them.

Outputs:
- all_halted = both states HALTED (combinational from the state registers).
- Latency: input change to visible issue is 1 cycle.

Test Plan:
- Reset, thread_enable=2'b11, fetch_ready=1 -> cycle 1 both RUN (thread_state=4'b0101). Issues are T0@0000, T1@0080, T0@0001, T1@0081; no bubbles.
- stall_req=2'b10 for 3 cycles with STRICT_ALT=0 -> T0 issues 3 consecutive PCs, thread_state[3:2]=10. After release, alternation resumes from T1@0081.
- Same stimulus with STRICT_ALT=1 -> T0, bubble, T0 pattern; bubble_count increments by 1 per bubble.
- fetch_ready=0 for 4 cycles while T1@0081 is presented -> issue outputs stable; pc1 stays 0082.
- Redirect T0 to 0x0040 in the cycle T0 is selected -> issue_pc=0040, next T0 issue is 0041.
- halt T0 then halt T1 -> states 11 each; all_halted=1; issue_valid=0 forever. bubble_count saturates at FFFF (preload-force check); rst mid-stream clears to reset values.

Source files
------------

// File: rtl/thread_scheduler.sv
// Round-robin issue scheduler for the 2-thread interleaved core.
// Tracks per-thread PC and run state and offers one {tid, pc} per cycle to fetch.
module thread_scheduler #(
  parameter int unsigned     PC_W       = 16,
  parameter int unsigned     PC_INC     = 1,
  parameter logic [PC_W-1:0] RESET_PC0  = 16'h0000,
  parameter logic [PC_W-1:0] RESET_PC1  = 16'h0080,
  parameter bit              STRICT_ALT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      thread_enable,
  input  logic [1:0]      stall_req,
  input  logic            redirect_valid,
  input  logic            redirect_tid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt_valid,
  input  logic            halt_tid,
  input  logic            fetch_ready,
  output logic            issue_valid,
  output logic            issue_tid,
  output logic [PC_W-1:0] issue_pc,
  output logic [3:0]      thread_state,
  output logic            all_halted,
  output logic [15:0]     bubble_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STALL  = 2'b10,
    HALTED = 2'b11
  } tstate_e;

  tstate_e         state     [2];
  tstate_e         state_nxt [2];
  logic [PC_W-1:0] pc        [2];
  logic            last_tid;
  logic            prev_issue;

  logic [1:0]      halt_hit;
  logic [1:0]      elig;
  logic            advance;
  logic            do_issue;
  logic            sel;
  logic            last_ok;
  logic [PC_W-1:0] sel_pc;

  assign halt_hit = {halt_valid & halt_tid, halt_valid & ~halt_tid};

  always_comb begin
    for (int unsigned t = 0; t < 2; t++) begin
      state_nxt[t] = state[t];
      elig[t]      = (state[t] == RUN) && !stall_req[t] && thread_enable[t] && !halt_hit[t];
      if (state[t] != HALTED) begin
        if (halt_hit[t]) begin
          state_nxt[t] = HALTED;
        end else if (!thread_enable[t]) begin
          state_nxt[t] = IDLE;
        end else begin
          case (state[t])
            IDLE:    state_nxt[t] = RUN;
            RUN:     if (stall_req[t])  state_nxt[t] = STALL;
            STALL:   if (!stall_req[t]) state_nxt[t] = RUN;
            default: state_nxt[t] = state[t];
          endcase
        end
      end
    end
  end

  // Under strict alternation the previous winner may only repeat after a bubble.
  always_comb begin
    advance  = !issue_valid || fetch_ready;
    last_ok  = elig[last_tid] && !(STRICT_ALT && prev_issue);
    do_issue = 1'b0;
    sel      = ~last_tid;
    if (elig[~last_tid]) begin
      do_issue = 1'b1;
      sel      = ~last_tid;
    end else if (last_ok) begin
      do_issue = 1'b1;
      sel      = last_tid;
    end
    sel_pc = (redirect_valid && (redirect_tid == sel)) ? redirect_pc : pc[sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state[0]     <= IDLE;
      state[1]     <= IDLE;
      pc[0]        <= RESET_PC0;
      pc[1]        <= RESET_PC1;
      last_tid     <= 1'b1;
      prev_issue   <= 1'b0;
      issue_valid  <= 1'b0;
      issue_tid    <= 1'b0;
      issue_pc     <= '0;
      bubble_count <= '0;
    end else begin
      state[0] <= state_nxt[0];
      state[1] <= state_nxt[1];
      if (redirect_valid) pc[redirect_tid] <= redirect_pc;
      if (advance) begin
        if (do_issue) begin
          // Overrides the plain redirect write above; sel_pc already carries the bypass.
          issue_valid <= 1'b1;
          issue_tid   <= sel;
          issue_pc    <= sel_pc;
          pc[sel]     <= sel_pc + PC_W'(PC_INC);
          last_tid    <= sel;
          prev_issue  <= 1'b1;
        end else begin
          issue_valid <= 1'b0;
          prev_issue  <= 1'b0;
          if (bubble_count != '1) bubble_count <= bubble_count + 16'd1;
        end
      end
    end
  end

  assign thread_state = {state[1], state[0]};
  assign all_halted   = (state[0] == HALTED) && (state[1] == HALTED);

endmodule
